codificador_sequencia: RTL and testbench

//  Transmit-side counterpart of the code-sequence decoder. Accepts a 4-bit target symbol and

---
 rtl/codificador_sequencia_if.sv | 23 ++
 rtl/codificador_sequencia.sv | 138 +++++++++++++
 tb/tb_codificador_sequencia.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/codificador_sequencia_if.sv
// Handshake bundle between the symbol issuer, the code-sequence encoder and the decoder input.
// The encoder owns the word stream, so it takes the master view; the environment takes the slave view.
interface codificador_sequencia_if;
  logic [3:0] Simbolo;
  logic       Iniciar;
  logic       Aceito;
  logic [6:0] Saida;
  logic       Valido;
  logic       Pronto;
  logic       Fim;
  logic       Erro;
  logic       Ocupado;

  modport master (
    input  Simbolo, Iniciar, Pronto,
    output Aceito, Saida, Valido, Fim, Erro, Ocupado
  );

  modport slave (
    output Simbolo, Iniciar, Pronto,
    input  Aceito, Saida, Valido, Fim, Erro, Ocupado
  );
endinterface

// File: rtl/codificador_sequencia.sv
// Code-sequence encoder: turns a 4-bit target symbol into the ordered 7-bit code words
// that walk the decoder from 0000 to that symbol, one word per valid/ready transfer.
module codificador_sequencia #(
  parameter logic [6:0] C1        = 7'b0000001,
  parameter logic [6:0] C2        = 7'b0000010,
  parameter logic [6:0] C3        = 7'b0000100,
  parameter logic [6:0] C4        = 7'b0001000,
  parameter logic [6:0] C5        = 7'b0010000,
  parameter logic [6:0] C6        = 7'b0100000,
  parameter logic [6:0] IDLE_CODE = 7'b0000000,
  parameter int         GAP       = 2
) (
  input  logic                          clk,
  input  logic                          Reset,
  codificador_sequencia_if.master       bus
);

  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [3:0]       r_simbolo;
  logic             r_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [6:0]       r_saida;
  logic             r_valido;
  logic             r_fim;
  logic             r_erro;
  logic             r_ocupado;

  logic             w_sym_ok;
  logic             w_more;

  // Low three bits select the first-level word; bit 3 adds the second-level C6 step.
  function automatic logic [6:0] word_at(input logic [3:0] sym, input logic idx);
    logic [6:0] w;
    if (idx) begin
      w = C6;
    end else begin
      case (sym[2:0])
        3'd1:    w = C1;
        3'd2:    w = C2;
        3'd3:    w = C3;
        3'd4:    w = C4;
        3'd5:    w = C5;
        default: w = IDLE_CODE;
      endcase
    end
    return w;
  endfunction

  assign w_sym_ok = (bus.Simbolo[2:0] >= 3'd1) && (bus.Simbolo[2:0] <= 3'd5);
  assign w_more   = r_simbolo[3] && !r_idx;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_simbolo <= '0;
      r_idx     <= 1'b0;
      r_gap_cnt <= '0;
      r_saida   <= IDLE_CODE;
      r_valido  <= 1'b0;
      r_fim     <= 1'b0;
      r_erro    <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      // NOTE: state and outputs use non-blocking assignments so every branch sees the
      // pre-edge values; the pulse outputs default low here and are raised only where needed.
      r_fim  <= 1'b0;
      r_erro <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.Iniciar) begin
            if (w_sym_ok) begin
              r_state   <= S_SEND;
              r_simbolo <= bus.Simbolo;
              r_idx     <= 1'b0;
              r_saida   <= word_at(bus.Simbolo, 1'b0);
              r_valido  <= 1'b1;
              r_ocupado <= 1'b1;
            end else begin
              r_erro <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (bus.Pronto) begin
            if (w_more) begin
              r_idx <= 1'b1;
              if (GAP > 0) begin
                r_state   <= S_GAP;
                r_gap_cnt <= '0;
                r_valido  <= 1'b0;
                r_saida   <= IDLE_CODE;
              end else begin
                r_saida <= word_at(r_simbolo, 1'b1);
              end
            end else begin
              r_state   <= S_IDLE;
              r_valido  <= 1'b0;
              r_saida   <= IDLE_CODE;
              r_fim     <= 1'b1;
              r_ocupado <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state  <= S_SEND;
            r_saida  <= word_at(r_simbolo, r_idx);
            r_valido <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Aceito follows the state directly so a request in the Fim cycle is taken back-to-back.
  assign bus.Aceito  = (r_state == S_IDLE);
  assign bus.Saida   = r_saida;
  assign bus.Valido  = r_valido;
  assign bus.Fim     = r_fim;
  assign bus.Erro    = r_erro;
  assign bus.Ocupado = r_ocupado;

endmodule

// File: tb/tb_codificador_sequencia.sv
// Bench for codificador_sequencia: symbol table vectors, hand-made corner sequences and random
// traffic checked every cycle against a transaction-level model of the word stream.
module tb_codificador_sequencia;

  localparam int GAP = 2;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  codificador_sequencia_if bus ();

  codificador_sequencia #(.GAP(GAP)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference rules: level 1..5 in the low bits selects one-hot word 1<<(level-1); bit 3 adds C6.
  function automatic int seq_len(input logic [3:0] s);
    int lvl;
    lvl = int'(s[2:0]);
    if (lvl < 1 || lvl > 5) return 0;
    return s[3] ? 2 : 1;
  endfunction

  function automatic logic [6:0] seq_word(input logic [3:0] s, input int k);
    int lvl;
    lvl = int'(s[2:0]);
    if (k == 0) return 7'(1 << (lvl - 1));
    return 7'h20;
  endfunction

  // Cycle monitor: queue of words still owed, remaining gap cycles, pending pulses.
  logic [6:0] exp_q[$];
  int         gap_left = 0;
  bit         exp_fim  = 1'b0;
  bit         exp_erro = 1'b0;
  bit         m_busy;
  bit         m_valid;

  initial begin
    forever begin
      @(negedge clk);
      if (!Reset) begin
        check("rst_valido",  bus.Valido,  1'b0);
        check("rst_saida",   bus.Saida,   7'h00);
        check("rst_fim",     bus.Fim,     1'b0);
        check("rst_erro",    bus.Erro,    1'b0);
        check("rst_ocupado", bus.Ocupado, 1'b0);
        check("rst_aceito",  bus.Aceito,  1'b1);
        exp_q.delete();
        gap_left = 0;
        exp_fim  = 1'b0;
        exp_erro = 1'b0;
      end else begin
        m_busy  = (exp_q.size() > 0);
        m_valid = m_busy && (gap_left == 0);
        check("mon_fim",     bus.Fim,     exp_fim);
        check("mon_erro",    bus.Erro,    exp_erro);
        check("mon_aceito",  bus.Aceito,  !m_busy);
        check("mon_ocupado", bus.Ocupado, m_busy);
        check("mon_valido",  bus.Valido,  m_valid);
        if (m_valid) check("mon_saida", bus.Saida, exp_q[0]);
        else         check("mon_saida_idle", bus.Saida, 7'h00);

        exp_fim  = 1'b0;
        exp_erro = 1'b0;
        if (m_valid && bus.Pronto) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) exp_fim = 1'b1;
          else                   gap_left = GAP;
        end else if (gap_left > 0) begin
          gap_left--;
        end
        if (bus.Iniciar && !m_busy) begin
          if (seq_len(bus.Simbolo) == 0) exp_erro = 1'b1;
          else for (int k = 0; k < seq_len(bus.Simbolo); k++) exp_q.push_back(seq_word(bus.Simbolo, k));
        end
      end
    end
  end

  task automatic request(input logic [3:0] s);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (!bus.Aceito && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("req_wait_aceito", (k < 200), 1'b1);
    bus.Simbolo = s;
    bus.Iniciar = 1'b1;
    @(posedge clk); #1;
    bus.Iniciar = 1'b0;
  endtask

  task automatic run_seq(input logic [3:0] s, output int n, output logic [6:0] w0,
                         output logic [6:0] w1, output bit err, output bit done);
    request(s);
    n = 0; w0 = 7'h00; w1 = 7'h00; err = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.Valido && bus.Pronto) begin
        if (n == 0) w0 = bus.Saida;
        else        w1 = bus.Saida;
        n++;
      end
      if (bus.Fim || bus.Erro) begin
        err  = bus.Erro;
        done = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [3:0] sym;
    int         n;
    logic [6:0] w0;
    logic [6:0] w1;
    bit         err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #500000;
    n_checks++;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int         n;
    logic [6:0] w0, w1;
    bit         err, done;
    int         k;

    vecs[0]  = '{4'b0000, 0, 7'h00, 7'h00, 1'b1};
    vecs[1]  = '{4'b0001, 1, 7'h01, 7'h00, 1'b0};
    vecs[2]  = '{4'b0010, 1, 7'h02, 7'h00, 1'b0};
    vecs[3]  = '{4'b0011, 1, 7'h04, 7'h00, 1'b0};
    vecs[4]  = '{4'b0100, 1, 7'h08, 7'h00, 1'b0};
    vecs[5]  = '{4'b0101, 1, 7'h10, 7'h00, 1'b0};
    vecs[6]  = '{4'b0110, 0, 7'h00, 7'h00, 1'b1};
    vecs[7]  = '{4'b0111, 0, 7'h00, 7'h00, 1'b1};
    vecs[8]  = '{4'b1000, 0, 7'h00, 7'h00, 1'b1};
    vecs[9]  = '{4'b1001, 2, 7'h01, 7'h20, 1'b0};
    vecs[10] = '{4'b1010, 2, 7'h02, 7'h20, 1'b0};
    vecs[11] = '{4'b1011, 2, 7'h04, 7'h20, 1'b0};
    vecs[12] = '{4'b1100, 2, 7'h08, 7'h20, 1'b0};
    vecs[13] = '{4'b1101, 2, 7'h10, 7'h20, 1'b0};
    vecs[14] = '{4'b1110, 0, 7'h00, 7'h00, 1'b1};
    vecs[15] = '{4'b1111, 0, 7'h00, 7'h00, 1'b1};

    bus.Simbolo = 4'h0;
    bus.Iniciar = 1'b0;
    bus.Pronto  = 1'b1;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #11;
    check("init_aceito",  bus.Aceito,  1'b1);
    check("init_valido",  bus.Valido,  1'b0);
    check("init_saida",   bus.Saida,   7'h00);
    check("init_ocupado", bus.Ocupado, 1'b0);
    #10 Reset = 1'b1;

    // Whole symbol table with the downstream always ready.
    for (int i = 0; i < 16; i++) begin
      run_seq(vecs[i].sym, n, w0, w1, err, done);
      check($sformatf("tab_done_%b", vecs[i].sym), done, 1'b1);
      check($sformatf("tab_err_%b",  vecs[i].sym), err,  vecs[i].err);
      check($sformatf("tab_n_%b",    vecs[i].sym), n,    vecs[i].n);
      check($sformatf("tab_w0_%b",   vecs[i].sym), w0,   vecs[i].w0);
      check($sformatf("tab_w1_%b",   vecs[i].sym), w1,   vecs[i].w1);
    end

    // Backpressure: C1 must stay on the bus while Pronto is low.
    bus.Pronto = 1'b0;
    request(4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valido", bus.Valido, 1'b1);
      check("hold_saida",  bus.Saida,  7'h01);
    end
    @(posedge clk); #1;
    bus.Pronto = 1'b1;
    @(posedge clk); #1;
    check("hold_fim", bus.Fim, 1'b1);

    // Reset in the gap of a two-word sequence aborts at once, then normal operation resumes.
    request(4'b1101);
    @(posedge clk); #1;
    check("gap_entered", bus.Valido, 1'b0);
    Reset = 1'b0;
    #1;
    check("abort_aceito",  bus.Aceito,  1'b1);
    check("abort_ocupado", bus.Ocupado, 1'b0);
    check("abort_valido",  bus.Valido,  1'b0);
    check("abort_fim",     bus.Fim,     1'b0);
    repeat (2) @(posedge clk);
    #3 Reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_fim", bus.Fim, 1'b0);
    end
    run_seq(4'b0100, n, w0, w1, err, done);
    check("after_abort_n",  n,  1);
    check("after_abort_w0", w0, 7'h08);

    // Requests while busy are ignored; a request in the Fim cycle starts the next sequence.
    bus.Pronto = 1'b0;
    request(4'b1001);
    for (int i = 0; i < 4; i++) begin
      bus.Iniciar = 1'b1;
      bus.Simbolo = 4'($urandom);
      @(posedge clk); #1;
      check("busy_ignore_saida", bus.Saida, 7'h01);
    end
    bus.Simbolo = 4'b0011;
    bus.Pronto  = 1'b1;
    k = 0;
    while (!bus.Fim && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("b2b_fim",    bus.Fim,    1'b1);
    check("b2b_aceito", bus.Aceito, 1'b1);
    @(posedge clk); #1;
    bus.Iniciar = 1'b0;
    check("b2b_valido", bus.Valido, 1'b1);
    check("b2b_saida",  bus.Saida,  7'h04);
    repeat (4) @(posedge clk);

    // Random traffic against the monitor model.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.Pronto  = ($urandom_range(0, 3) != 0);
      bus.Iniciar = ($urandom_range(0, 2) == 0);
      bus.Simbolo = 4'($urandom);
    end
    bus.Iniciar = 1'b0;
    bus.Pronto  = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("drain_idle", bus.Aceito, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
